// File: rtl/sr_chk_pkg.sv
// Shared types for the SR flip-flop checker: FSM state encoding, default counter
// width and the next-state predictor of an ideal SR flip-flop.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        CHECK  = 2'd0,
        RESYNC = 2'd1,
        FAIL   = 2'd2
    } chk_state_t;

    localparam int DEF_CNT_W = 8;

    // s=r=1 has no defined result, so it leaves cur untouched; callers resync instead.
    function automatic logic sr_predict(input logic cur, input logic s, input logic r);
        case ({s, r})
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/sr_chk_sat_cnt.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sr_chk_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sr_ff_checker.sv
// Runtime checker for an SR flip-flop: predicts q, flags mismatches and s=r=1 samples.
// Define SR_CHK_STOP_ON_ERR_EN to latch into FAIL on the first mismatch.
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int   CNT_W   = DEF_CNT_W,
    parameter logic RESET_Q = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             clr,
    output logic             mismatch,
    output logic             illegal,
    output logic             err_sticky,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [1:0]       state
);

`ifdef SR_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    chk_state_t state_q, state_d;
    logic       exp_q, exp_d;
    logic       mis_evt, ill_evt;
    logic       mismatch_p1, illegal_p1, sticky_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CHECK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CHECK: begin
                if (STOP_ON_ERR && (q != exp_q)) begin
                    state_d = FAIL;
                end else if (s && r) begin
                    state_d = RESYNC;
                end
            end
            RESYNC:  state_d = (s && r) ? RESYNC : CHECK;
            FAIL:    state_d = STOP_ON_ERR ? FAIL : CHECK;
            default: state_d = CHECK;
        endcase
    end

    // Leaving RESYNC, the sampled q is the new baseline; this edge's s/r still apply on top of it.
    always_comb begin
        mis_evt = 1'b0;
        ill_evt = 1'b0;
        exp_d   = exp_q;
        case (state_q)
            CHECK: begin
                mis_evt = (q != exp_q);
                ill_evt = s && r;
                exp_d   = sr_predict(exp_q, s, r);
            end
            RESYNC: begin
                ill_evt = s && r;
                exp_d   = sr_predict(q, s, r);
            end
            default: ;
        endcase
    end

    // p1: events registered so every output lags its sampling edge by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= RESET_Q;
            mismatch_p1 <= 1'b0;
            illegal_p1  <= 1'b0;
            sticky_p1   <= 1'b0;
        end else begin
            exp_q       <= exp_d;
            mismatch_p1 <= mis_evt;
            illegal_p1  <= ill_evt;
            sticky_p1   <= clr ? 1'b0 : (sticky_p1 | mis_evt);
        end
    end

    sr_chk_sat_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (mis_evt),
        .cnt (mismatch_cnt)
    );

    sr_chk_sat_cnt #(.CNT_W(CNT_W)) u_ill_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (ill_evt),
        .cnt (illegal_cnt)
    );

    assign mismatch   = mismatch_p1;
    assign illegal    = illegal_p1;
    assign err_sticky = sticky_p1;
    assign state      = state_q;

endmodule
